multdiv_req_arbiter: RTL and testbench
======================================

// Module: multdiv_req_arbiter
// PURPOSE
//  Sequencer and arbiter for one shared slow multiply/divide unit; two requesters (0 = core ID stage, 1 = coprocessor port).
//  Arbitrates round-robin and latches operands for the whole operation.
//  Owns the 2x34b intermediate-value registers and the 34b operand adder that the multdiv unit needs.
//  Returns the result on a valid/ready response channel. Sits between the requesters and the multdiv instance.
// PARAMETERS
//  MAX_CYCLES  48  watchdog limit on cycles spent in BUSY; must be > 40 (worst-case divide is 37 cycles)
// PORTS
//  clk_i             in   1     clock
//  rst_ni            in   1     reset: synchronous, active-low
//  req_i             in   2     per-requester request; held until gnt_o bit
//  req_op_i          in   2x sel_md_op_e  operator per requester
//  req_sgn_i         in   2x2   signed_mode per requester
//  req_a_i, req_b_i  in   2x32  operands per requester
//  req_dit_i         in   2     data-independent-timing request (MULTDIV_DIT_EN only)
//  gnt_o             out  2     one-hot grant pulse
//  rvalid_o          out  2     one-hot response valid, held until rready_i
//  rready_i          in   2     response ready
//  rdata_o           out  32    result
//  rerr_o            out  1     watchdog error flag, qualified by rvalid_o
//  md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o  out 1 each  multdiv control
//  md_operator_o     out  sel_md_op_e   latched operator
//  md_signed_mode_o  out  2     latched signed mode
//  md_op_a_o, md_op_b_o  out 32  latched operands
//  md_alu_operand_a_i, md_alu_operand_b_i  in 33  adder inputs from multdiv
//  md_alu_adder_ext_o  out 34   {1'b0,a}+{1'b0,b}
//  md_alu_adder_o    out  32    md_alu_adder_ext_o[32:1]
//  md_equal_to_zero_o  out 1    md_alu_adder_o == 0
//  md_data_ind_timing_o  out 1  latched DIT bit
//  md_imd_val_q_o    out  2x34  intermediate registers
//  md_imd_val_d_i    in   2x34  next intermediate values
//  md_imd_val_we_i   in   2     write enables
//  md_ready_id_o     out  1     1 in BUSY, 0 otherwise
//  md_result_i       in   32    multdiv result
//  md_valid_i        in   1     multdiv done
// BEHAVIOUR
//  Reset (sync, rst_ni=0 at posedge):
//   - state IDLE; every output 0; rr pointer 0; imd regs 0; watchdog counter 0.
//   - Reset mid-operation abandons the operation; no response is issued.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//   - IDLE: if any req_i, grant the winner; gnt_o[w]=1 for one cycle (combinational, same cycle).
//     Capture op/sgn/a/b(/dit) and owner w; clear the imd regs; go to BUSY.
//   - BUSY: mult_sel/en=1 iff latched op is MULL/MULH; div_sel/en=1 iff DIV/REM.
//     On md_valid_i: capture md_result_i into rdata, rerr=0, go to RESP.
//     If the watchdog counter reaches MAX_CYCLES-1 without md_valid_i: rdata=32'hFFFF_FFFF, rerr=1, go to RESP.
//   - RESP: rvalid_o[owner]=1 with rdata/rerr stable; on rready_i[owner] go to IDLE.
//     Earliest new grant is the cycle after that IDLE entry (one idle cycle minimum).
//  Control drop: en/sel fall on the cycle after md_valid_i, so multdiv returns to idle without restarting.
//  Arbitration:
//   - Single request wins outright.
//   - Both requesting: requester == rr pointer wins; after each grant the pointer = ~winner.
//   - Requests arriving in BUSY/RESP wait; no grant is given outside IDLE.
//  Imd regs: reg[k] <= md_imd_val_d_i[k] when md_imd_val_we_i[k] and state==BUSY.
//  Watchdog: increments each BUSY cycle; cleared on entry to BUSY; saturates.
//  Operand latches are stable from the BUSY entry until the next grant; requester inputs are ignored after gnt.
// CONFIGURATION
//  MULTDIV_DIT_EN defined:
//   - req_dit_i[w] is latched at grant and driven on md_data_ind_timing_o throughout BUSY.
//  MULTDIV_DIT_EN undefined:
//   - req_dit_i is ignored and md_data_ind_timing_o is tied 0.
//   - Multiply-by-0/1 and divide-by-0 take the short paths.
// STRUCTURE
//  pck_control additions:
//   - md_arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESP}
//   - MD_ARB_NREQ = 2
//   - function md_is_mult(sel_md_op_e)
//  Sub-module md_rr_arbiter2: 2-way round-robin pick with pointer register; outputs one-hot winner and valid.
//  The adder, imd regs, watchdog and FSM live in the top.
// TESTING (bench instantiates ibex_multdiv_slow)
//  1. Req0 MULL a=7 b=6, rready tied 1 -> gnt_o=01 in the request cycle; rvalid_o=01, rdata=42, rerr=0.
//  2. Req1 DIV sgn=11 a=-20 b=3 -> rdata=32'hFFFF_FFFA (-6); REM same operands -> 32'hFFFF_FFFE (-2).
//  3. Req0 REM a=5 b=0 -> rdata=5; DIV a=5 b=0 -> 32'hFFFF_FFFF. Both finish in under 6 cycles without DIT.
//  4. Both request MULL from reset, held -> grant order 0,1,0,1; each response goes only to its owner's rvalid bit.
//  5. rready_i[0]=0 for 10 cycles during RESP -> rvalid/rdata held; req1 stays ungranted until the handshake completes.
//  6. md_valid_i forced 0 (stub) -> rerr=1, rdata=32'hFFFF_FFFF after MAX_CYCLES BUSY cycles; rst_ni=0 mid-BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/multdiv_req_arbiter_pkg.sv
// Shared types, sizes and helpers for the multdiv request arbiter.
// MULTDIV_DIT_EN (optional) enables latching of the data-independent-timing request.
package multdiv_req_arbiter_pkg;

  localparam int unsigned MD_ARB_NREQ = 2;
  localparam int unsigned MD_DATA_W   = 32;
  localparam int unsigned MD_ALU_W    = 33;
  localparam int unsigned MD_IMD_W    = 34;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } sel_md_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } md_arb_state_e;

  // Operation captured from the winning requester at grant time.
  typedef struct packed {
    sel_md_op_e           op;
    logic [1:0]           sgn;
    logic [MD_DATA_W-1:0] a;
    logic [MD_DATA_W-1:0] b;
    logic                 dit;
  } md_req_t;

  function automatic logic md_is_mult(sel_md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/multdiv_req_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; the pointer names the requester that wins a tie.
module md_rr_arbiter2
  import multdiv_req_arbiter_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [MD_ARB_NREQ-1:0] req_i,
  input  logic                   en_i,
  output logic [MD_ARB_NREQ-1:0] gnt_o,
  output logic                   valid_o
);

  logic ptr_q;
  logic win;

  assign win     = (req_i == 2'b11) ? ptr_q : req_i[1];
  assign valid_o = en_i && (req_i != '0);
  assign gnt_o   = valid_o ? (win ? 2'b10 : 2'b01) : 2'b00;

  // After each grant the other requester gets priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (valid_o) begin
      ptr_q <= ~win;
    end
  end

endmodule

// File: rtl/multdiv_req_arbiter.sv
// Sequencer/arbiter in front of one shared slow multiply/divide unit.
// Optional MULTDIV_DIT_EN forwards the winner's data-independent-timing request.
module multdiv_req_arbiter
  import multdiv_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 48
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [MD_ARB_NREQ-1:0]                req_i,
  input  sel_md_op_e [MD_ARB_NREQ-1:0]          req_op_i,
  input  logic [MD_ARB_NREQ-1:0][1:0]           req_sgn_i,
  input  logic [MD_ARB_NREQ-1:0][MD_DATA_W-1:0] req_a_i,
  input  logic [MD_ARB_NREQ-1:0][MD_DATA_W-1:0] req_b_i,
  input  logic [MD_ARB_NREQ-1:0]                req_dit_i,
  output logic [MD_ARB_NREQ-1:0]                gnt_o,
  output logic [MD_ARB_NREQ-1:0]                rvalid_o,
  input  logic [MD_ARB_NREQ-1:0]                rready_i,
  output logic [MD_DATA_W-1:0]                  rdata_o,
  output logic                                  rerr_o,
  output logic                                  md_mult_en_o,
  output logic                                  md_div_en_o,
  output logic                                  md_mult_sel_o,
  output logic                                  md_div_sel_o,
  output sel_md_op_e                            md_operator_o,
  output logic [1:0]                            md_signed_mode_o,
  output logic [MD_DATA_W-1:0]                  md_op_a_o,
  output logic [MD_DATA_W-1:0]                  md_op_b_o,
  input  logic [MD_ALU_W-1:0]                   md_alu_operand_a_i,
  input  logic [MD_ALU_W-1:0]                   md_alu_operand_b_i,
  output logic [MD_IMD_W-1:0]                   md_alu_adder_ext_o,
  output logic [MD_DATA_W-1:0]                  md_alu_adder_o,
  output logic                                  md_equal_to_zero_o,
  output logic                                  md_data_ind_timing_o,
  output logic [1:0][MD_IMD_W-1:0]              md_imd_val_q_o,
  input  logic [1:0][MD_IMD_W-1:0]              md_imd_val_d_i,
  input  logic [1:0]                            md_imd_val_we_i,
  output logic                                  md_ready_id_o,
  input  logic [MD_DATA_W-1:0]                  md_result_i,
  input  logic                                  md_valid_i
);

  localparam int unsigned CNT_W = $clog2(MAX_CYCLES);

  md_arb_state_e                state_q;
  md_req_t                      req_q;
  md_req_t                      win_req;
  logic                         owner_q;
  logic [MD_ARB_NREQ-1:0]       rvalid_q;
  logic [MD_DATA_W-1:0]         rdata_q;
  logic                         rerr_q;
  logic                         mult_q;
  logic                         div_q;
  logic [CNT_W-1:0]             wdog_q;
  logic [1:0][MD_IMD_W-1:0]     imd_q;
  logic [MD_ARB_NREQ-1:0]       arb_gnt;
  logic                         arb_valid;
  logic                         arb_en;
  logic                         win_idx;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign arb_en  = rst_ni && (state_q == ARB_IDLE);
  assign win_idx = arb_gnt[1];

  md_rr_arbiter2 u_rr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .en_i    (arb_en),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    win_req     = '0;
    win_req.op  = req_op_i[win_idx];
    win_req.sgn = req_sgn_i[win_idx];
    win_req.a   = req_a_i[win_idx];
    win_req.b   = req_b_i[win_idx];
`ifdef MULTDIV_DIT_EN
    win_req.dit = req_dit_i[win_idx];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      req_q    <= '0;
      owner_q  <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (arb_valid) begin
            state_q <= ARB_BUSY;
            req_q   <= win_req;
            owner_q <= win_idx;
            wdog_q  <= '0;
            mult_q  <= md_is_mult(win_req.op);
            div_q   <= !md_is_mult(win_req.op);
          end
        end
        ARB_BUSY: begin
          if (wdog_q != {CNT_W{1'b1}}) begin
            wdog_q <= wdog_q + CNT_W'(1);
          end
          // Dropping en/sel on leaving BUSY keeps multdiv from restarting.
          if (md_valid_i || (wdog_q == CNT_W'(MAX_CYCLES - 1))) begin
            state_q  <= ARB_RESP;
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            rvalid_q <= MD_ARB_NREQ'(1) << owner_q;
            rdata_q  <= md_valid_i ? md_result_i : {MD_DATA_W{1'b1}};
            rerr_q   <= !md_valid_i;
          end
        end
        ARB_RESP: begin
          if (rready_i[owner_q]) begin
            state_q  <= ARB_IDLE;
            rvalid_q <= '0;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Intermediate values: cleared at grant, written by multdiv only while BUSY.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || arb_valid) begin
      imd_q <= '0;
    end else if (state_q == ARB_BUSY) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (md_imd_val_we_i[k]) begin
          imd_q[k] <= md_imd_val_d_i[k];
        end
      end
    end
  end

  assign md_alu_adder_ext_o = {1'b0, md_alu_operand_a_i} + {1'b0, md_alu_operand_b_i};
  assign md_alu_adder_o     = md_alu_adder_ext_o[MD_DATA_W:1];
  assign md_equal_to_zero_o = (md_alu_adder_o == '0);

  assign gnt_o            = arb_gnt;
  assign rvalid_o         = rvalid_q;
  assign rdata_o          = rdata_q;
  assign rerr_o           = rerr_q;
  assign md_mult_en_o     = mult_q;
  assign md_mult_sel_o    = mult_q;
  assign md_div_en_o      = div_q;
  assign md_div_sel_o     = div_q;
  assign md_operator_o    = req_q.op;
  assign md_signed_mode_o = req_q.sgn;
  assign md_op_a_o        = req_q.a;
  assign md_op_b_o        = req_q.b;
  assign md_imd_val_q_o   = imd_q;
  assign md_ready_id_o    = (state_q == ARB_BUSY);

`ifdef MULTDIV_DIT_EN
  assign md_data_ind_timing_o = req_q.dit && (state_q == ARB_BUSY);
`else
  logic unused_dit;
  assign unused_dit           = ^{req_dit_i, req_q.dit};
  assign md_data_ind_timing_o = 1'b0;
`endif

endmodule

// File: tb/tb_multdiv_req_arbiter.sv
// Self-checking bench for multdiv_req_arbiter with a behavioural multdiv stand-in.
module tb_multdiv_req_arbiter;
  import multdiv_req_arbiter_pkg::*;

  localparam int MAXC = 48;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [1:0]              req_i;
  sel_md_op_e [1:0]        req_op_i;
  logic [1:0][1:0]         req_sgn_i;
  logic [1:0][31:0]        req_a_i;
  logic [1:0][31:0]        req_b_i;
  logic [1:0]              req_dit_i;
  logic [1:0]              gnt_o;
  logic [1:0]              rvalid_o;
  logic [1:0]              rready_i;
  logic [31:0]             rdata_o;
  logic                    rerr_o;
  logic                    md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  sel_md_op_e              md_operator_o;
  logic [1:0]              md_signed_mode_o;
  logic [31:0]             md_op_a_o, md_op_b_o;
  logic [32:0]             md_alu_operand_a_i, md_alu_operand_b_i;
  logic [33:0]             md_alu_adder_ext_o;
  logic [31:0]             md_alu_adder_o;
  logic                    md_equal_to_zero_o;
  logic                    md_data_ind_timing_o;
  logic [1:0][33:0]        md_imd_val_q_o;
  logic [1:0][33:0]        md_imd_val_d_i;
  logic [1:0]              md_imd_val_we_i;
  logic                    md_ready_id_o;
  logic [31:0]             md_result_i = '0;
  logic                    md_valid_i = 1'b0;

  always #5 clk_i = ~clk_i;

  multdiv_req_arbiter #(.MAX_CYCLES(MAXC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_op_i(req_op_i),
    .req_sgn_i(req_sgn_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_dit_i(req_dit_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
    .rerr_o(rerr_o), .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_alu_operand_a_i(md_alu_operand_a_i), .md_alu_operand_b_i(md_alu_operand_b_i),
    .md_alu_adder_ext_o(md_alu_adder_ext_o), .md_alu_adder_o(md_alu_adder_o),
    .md_equal_to_zero_o(md_equal_to_zero_o), .md_data_ind_timing_o(md_data_ind_timing_o),
    .md_imd_val_q_o(md_imd_val_q_o), .md_imd_val_d_i(md_imd_val_d_i),
    .md_imd_val_we_i(md_imd_val_we_i), .md_ready_id_o(md_ready_id_o),
    .md_result_i(md_result_i), .md_valid_i(md_valid_i)
  );

  typedef struct {
    logic [1:0]  onehot;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic stub_kill = 1'b0;
  int   stub_cnt = 0;

  // RISC-V M semantics for the stand-in unit.
  function automatic logic [31:0] md_ref(sel_md_op_e op, logic [1:0] sgn,
                                         logic [31:0] a, logic [31:0] b);
    logic signed [32:0] sa, sbv;
    logic signed [65:0] sp;
    logic [31:0]        res;
    sa  = sgn[0] ? {a[31], a} : {1'b0, a};
    sbv = sgn[1] ? {b[31], b} : {1'b0, b};
    sp  = sa * sbv;
    case (op)
      MD_OP_MULL: res = sp[31:0];
      MD_OP_MULH: res = sp[63:32];
      MD_OP_DIV:  res = (b == 0) ? 32'hFFFF_FFFF :
                        (sgn == 2'b11) ? 32'($signed(a) / $signed(b)) : a / b;
      default:    res = (b == 0) ? a :
                        (sgn == 2'b11) ? 32'($signed(a) % $signed(b)) : a % b;
    endcase
    return res;
  endfunction

  // Stand-in multdiv: short path for divide-by-zero, long path for divide.
  always @(posedge clk_i) begin
    if (!rst_ni || stub_kill) begin
      md_valid_i <= 1'b0;
      stub_cnt   <= 0;
    end else if (md_valid_i) begin
      md_valid_i <= 1'b0;
      stub_cnt   <= 0;
    end else if (md_mult_en_o || md_div_en_o) begin
      if (stub_cnt >= (md_div_en_o ? ((md_op_b_o == 0) ? 1 : 34) : 2)) begin
        md_valid_i  <= 1'b1;
        md_result_i <= md_ref(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = '0; req_op_i = '{MD_OP_MULL, MD_OP_MULL}; req_sgn_i = '0;
    req_a_i = '0; req_b_i = '0; req_dit_i = '0; rready_i = 2'b11;
    md_alu_operand_a_i = '0; md_alu_operand_b_i = '0;
    md_imd_val_d_i = '0; md_imd_val_we_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic set_req(input int w, input sel_md_op_e op, input logic [1:0] sgn,
                         input logic [31:0] a, input logic [31:0] b);
    req_i[w] = 1'b1; req_op_i[w] = op; req_sgn_i[w] = sgn; req_a_i[w] = a; req_b_i[w] = b;
  endtask

  task automatic wait_gnt(output logic [1:0] g, output bit ok);
    ok = 1'b0; g = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (gnt_o != '0) begin g = gnt_o; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rvalid(output bit ok, output int busy);
    ok = 1'b0; busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (md_ready_id_o) busy++;
      if (rvalid_o != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    req_i = 2'b11;
    tick(); tick();
    @(negedge clk_i);
    total++;
    if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
    req_i = '0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if ({rvalid_o, rdata_o, rerr_o} !== '0) begin
      bad++; $display("FAIL reset_resp: got rvalid=%b rdata=%h rerr=%b want 0", rvalid_o, rdata_o, rerr_o);
    end
    total++;
    if ({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o, md_data_ind_timing_o} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {md_mult_en_o, md_div_en_o,
        md_mult_sel_o, md_div_sel_o, md_ready_id_o, md_data_ind_timing_o});
    end
    total++;
    if ({md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_imd_val_q_o} !== '0) begin
      bad++; $display("FAIL reset_latch: got a=%h b=%h imd=%h want 0", md_op_a_o, md_op_b_o, md_imd_val_q_o);
    end
  endtask

  task automatic test_adder();
    md_alu_operand_a_i = 33'h1_FFFF_FFFF; md_alu_operand_b_i = 33'h0_0000_0001;
    #1;
    total++;
    if ({md_alu_adder_ext_o, md_alu_adder_o, md_equal_to_zero_o} !== {34'h2_0000_0000, 32'h0, 1'b1}) begin
      bad++; $display("FAIL adder_carry: got ext=%h add=%h z=%b want 200000000 00000000 1",
        md_alu_adder_ext_o, md_alu_adder_o, md_equal_to_zero_o);
    end
    md_alu_operand_a_i = 33'h4; md_alu_operand_b_i = 33'h6;
    #1;
    total++;
    if ({md_alu_adder_ext_o, md_alu_adder_o, md_equal_to_zero_o} !== {34'h000_0000A, 32'h5, 1'b0}) begin
      bad++; $display("FAIL adder_small: got ext=%h add=%h z=%b want 00000000a 00000005 0",
        md_alu_adder_ext_o, md_alu_adder_o, md_equal_to_zero_o);
    end
    md_alu_operand_a_i = '0; md_alu_operand_b_i = '0;
  endtask

  task automatic test_mull();
    exp_t e; bit ok; int busy;
    tick();
    set_req(0, MD_OP_MULL, 2'b00, 32'd7, 32'd6);
    sb.push_back('{2'b01, 32'd42, 1'b0});
    @(negedge clk_i);
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL mull_gnt: got %b want 01", gnt_o); end
    tick();
    req_i[0] = 1'b0;
    md_imd_val_we_i = 2'b01; md_imd_val_d_i[0] = 34'h2_1234_5678; md_imd_val_d_i[1] = 34'h1_1111_1111;
    tick();
    md_imd_val_we_i = '0;
    @(negedge clk_i);
    total++;
    if ({md_mult_en_o, md_div_en_o, md_operator_o, md_op_a_o, md_op_b_o} !== {1'b1, 1'b0, MD_OP_MULL, 32'd7, 32'd6}) begin
      bad++; $display("FAIL mull_busy: got men=%b den=%b a=%0d b=%0d want 1 0 7 6",
        md_mult_en_o, md_div_en_o, md_op_a_o, md_op_b_o);
    end
    total++;
    if (md_imd_val_q_o !== {34'h0, 34'h2_1234_5678}) begin
      bad++; $display("FAIL imd_write: got %h want %h", md_imd_val_q_o, {34'h0, 34'h2_1234_5678});
    end
    wait_rvalid(ok, busy);
    e = sb.pop_front();
    total++;
    if (!ok) begin bad++; $display("FAIL mull_rvalid: got timeout want response"); end
    else if ({rvalid_o, rdata_o, rerr_o, md_mult_en_o} !== {e.onehot, e.data, e.err, 1'b0}) begin
      bad++; $display("FAIL mull_resp: got v=%b d=%h e=%b en=%b want v=%b d=%h e=%b en=0",
        rvalid_o, rdata_o, rerr_o, md_mult_en_o, e.onehot, e.data, e.err);
    end
  endtask

  task automatic test_div_signed();
    exp_t e; bit ok; int busy; logic [1:0] g;
    sel_md_op_e  ops[2]  = '{MD_OP_DIV, MD_OP_REM};
    logic [31:0] exps[2] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE};
    for (int i = 0; i < 2; i++) begin
      tick();
      set_req(1, ops[i], 2'b11, 32'hFFFF_FFEC, 32'd3);
      sb.push_back('{2'b10, exps[i], 1'b0});
      wait_gnt(g, ok);
      total++;
      if (g !== 2'b10) begin bad++; $display("FAIL div_gnt%0d: got %b want 10", i, g); end
      tick();
      req_i[1] = 1'b0;
      @(negedge clk_i);
      total++;
      if (md_imd_val_q_o !== '0) begin bad++; $display("FAIL imd_clear%0d: got %h want 0", i, md_imd_val_q_o); end
      wait_rvalid(ok, busy);
      e = sb.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL div_rvalid%0d: got timeout want response", i); end
      else if ({rvalid_o, rdata_o, rerr_o} !== {e.onehot, e.data, e.err}) begin
        bad++; $display("FAIL div_resp%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b",
          i, rvalid_o, rdata_o, rerr_o, e.onehot, e.data, e.err);
      end
    end
  endtask

  task automatic test_div_by_zero();
    exp_t e; bit ok; int busy; logic [1:0] g;
    sel_md_op_e  ops[2]  = '{MD_OP_REM, MD_OP_DIV};
    logic [31:0] exps[2] = '{32'd5, 32'hFFFF_FFFF};
    for (int i = 0; i < 2; i++) begin
      tick();
      set_req(0, ops[i], 2'b00, 32'd5, 32'd0);
      sb.push_back('{2'b01, exps[i], 1'b0});
      wait_gnt(g, ok);
      tick();
      req_i[0] = 1'b0;
      wait_rvalid(ok, busy);
      e = sb.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL dz_rvalid%0d: got timeout want response", i); end
      else if ({rvalid_o, rdata_o, rerr_o} !== {e.onehot, e.data, e.err}) begin
        bad++; $display("FAIL dz_resp%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b",
          i, rvalid_o, rdata_o, rerr_o, e.onehot, e.data, e.err);
      end
      total++;
      if (busy >= 6) begin bad++; $display("FAIL dz_latency%0d: got %0d busy cycles want <6", i, busy); end
    end
  endtask

  task automatic test_round_robin();
    exp_t e; bit ok; int busy; logic [1:0] g; logic [1:0] want;
    do_reset();
    set_req(0, MD_OP_MULL, 2'b00, 32'd3, 32'd4);
    set_req(1, MD_OP_MULL, 2'b00, 32'd5, 32'd6);
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(g, ok);
      total++;
      if (g !== want) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", i, g, want); end
      sb.push_back('{want, (i % 2 == 0) ? 32'd12 : 32'd30, 1'b0});
      if (i == 3) begin tick(); req_i = '0; end
      wait_rvalid(ok, busy);
      e = sb.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL rr_rvalid%0d: got timeout want response", i); end
      else if ({rvalid_o, rdata_o} !== {e.onehot, e.data}) begin
        bad++; $display("FAIL rr_resp%0d: got v=%b d=%h want v=%b d=%h", i, rvalid_o, rdata_o, e.onehot, e.data);
      end
    end
  endtask

  task automatic test_resp_hold();
    exp_t e; bit ok; int busy; logic [1:0] g;
    rready_i = 2'b10;
    tick();
    set_req(0, MD_OP_MULL, 2'b00, 32'd9, 32'd9);
    sb.push_back('{2'b01, 32'd81, 1'b0});
    wait_gnt(g, ok);
    tick();
    req_i[0] = 1'b0;
    wait_rvalid(ok, busy);
    e = sb.pop_front();
    total++;
    if (!ok) begin bad++; $display("FAIL hold_rvalid: got timeout want response"); end
    else if ({rvalid_o, rdata_o} !== {e.onehot, e.data}) begin
      bad++; $display("FAIL hold_resp: got v=%b d=%h want v=%b d=%h", rvalid_o, rdata_o, e.onehot, e.data);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) set_req(1, MD_OP_MULL, 2'b00, 32'd2, 32'd8);
      @(negedge clk_i);
      total++;
      if ({rvalid_o, rdata_o, gnt_o} !== {2'b01, 32'd81, 2'b00}) begin
        bad++; $display("FAIL hold_cyc%0d: got v=%b d=%h g=%b want 01 00000051 00", i, rvalid_o, rdata_o, gnt_o);
      end
    end
    tick();
    rready_i = 2'b11;
    @(negedge clk_i);
    total++;
    if ({rvalid_o, gnt_o} !== {2'b01, 2'b00}) begin
      bad++; $display("FAIL hold_hs: got v=%b g=%b want 01 00", rvalid_o, gnt_o);
    end
    sb.push_back('{2'b10, 32'd16, 1'b0});
    @(negedge clk_i);
    total++;
    if ({rvalid_o, gnt_o} !== {2'b00, 2'b10}) begin
      bad++; $display("FAIL hold_next_gnt: got v=%b g=%b want 00 10", rvalid_o, gnt_o);
    end
    tick();
    req_i[1] = 1'b0;
    wait_rvalid(ok, busy);
    e = sb.pop_front();
    total++;
    if (!ok) begin bad++; $display("FAIL hold2_rvalid: got timeout want response"); end
    else if ({rvalid_o, rdata_o} !== {e.onehot, e.data}) begin
      bad++; $display("FAIL hold2_resp: got v=%b d=%h want v=%b d=%h", rvalid_o, rdata_o, e.onehot, e.data);
    end
  endtask

  task automatic test_watchdog_and_reset();
    exp_t e; bit ok; int busy; int stray; logic [1:0] g;
    stub_kill = 1'b1;
    tick();
    set_req(0, MD_OP_MULH, 2'b11, 32'd100, 32'd200);
    sb.push_back('{2'b01, 32'hFFFF_FFFF, 1'b1});
    wait_gnt(g, ok);
    tick();
    req_i[0] = 1'b0;
    wait_rvalid(ok, busy);
    e = sb.pop_front();
    total++;
    if (!ok) begin bad++; $display("FAIL wd_rvalid: got timeout want response"); end
    else if ({rvalid_o, rdata_o, rerr_o} !== {e.onehot, e.data, e.err}) begin
      bad++; $display("FAIL wd_resp: got v=%b d=%h e=%b want v=%b d=%h e=%b",
        rvalid_o, rdata_o, rerr_o, e.onehot, e.data, e.err);
    end
    total++;
    if (busy != MAXC) begin bad++; $display("FAIL wd_cycles: got %0d want %0d", busy, MAXC); end
    tick();
    set_req(1, MD_OP_DIV, 2'b00, 32'd77, 32'd7);
    wait_gnt(g, ok);
    tick();
    req_i[1] = 1'b0;
    md_imd_val_we_i = 2'b11; md_imd_val_d_i = {34'h3_0000_0001, 34'h1_0000_0002};
    repeat (4) tick();
    md_imd_val_we_i = '0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({gnt_o, rvalid_o, rdata_o, rerr_o, md_div_en_o, md_div_sel_o, md_ready_id_o,
         md_op_a_o, md_op_b_o, md_imd_val_q_o} !== '0) begin
      bad++; $display("FAIL midbusy_reset: got v=%b den=%b rdy=%b a=%h imd=%h want all 0",
        rvalid_o, md_div_en_o, md_ready_id_o, md_op_a_o, md_imd_val_q_o);
    end
    tick();
    rst_ni = 1'b1;
    stub_kill = 1'b0;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (rvalid_o != '0 || md_ready_id_o) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL abandon: got %0d active cycles want 0", stray); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_adder();
    test_mull();
    test_div_signed();
    test_div_by_zero();
    test_round_robin();
    test_resp_hold();
    test_watchdog_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
